// File: rtl/pipe_skid_buf_pkg.sv
// rtl/pipe_skid_buf_pkg.sv - shared types and occupancy constants for the skid buffer
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Entries held in a given state
  function automatic logic [1:0] occ_of(input skid_state_t s);
    case (s)
      BUSY:    occ_of = OCC_ONE;
      FULL:    occ_of = OCC_FULL;
      default: occ_of = OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_buf_ctrl.sv
// rtl/pipe_skid_buf_ctrl.sv - skid buffer FSM, registered handshake/occupancy and load enables
module pipe_skid_ctrl
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_s_valid,
  input  logic       i_m_ready,
  input  logic       i_flush,
  output logic       o_s_ready,
  output logic       o_m_valid,
  output logic [1:0] o_occ,
  output logic       o_load_main,
  output logic       o_load_skid,
  output logic       o_main_sel_skid
);

  skid_state_t r_state;
  skid_state_t w_state_nxt;
  logic        r_s_ready;
  logic        r_m_valid;
  logic [1:0]  r_occ;
  logic        w_in;
  logic        w_out;

  assign w_in  = i_s_valid & r_s_ready;
  assign w_out = r_m_valid & i_m_ready;

  // Next state and data-register load enables; flush overrides everything
  always_comb begin
    w_state_nxt     = r_state;
    o_load_main     = 1'b0;
    o_load_skid     = 1'b0;
    o_main_sel_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in) begin
          w_state_nxt = BUSY;
          o_load_main = 1'b1;
        end
      end
      BUSY: begin
        if (w_in && w_out) begin
          o_load_main = 1'b1;
        end else if (w_in) begin
          w_state_nxt = FULL;
          o_load_skid = 1'b1;
        end else if (w_out) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out) begin
          w_state_nxt     = BUSY;
          o_load_main     = 1'b1;
          o_main_sel_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    if (i_flush) begin
      w_state_nxt     = EMPTY;
      o_load_main     = 1'b0;
      o_load_skid     = 1'b0;
      o_main_sel_skid = 1'b0;
    end
  end

  // State plus handshake outputs registered from the next state, so no output is combinational
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= EMPTY;
      r_s_ready <= 1'b1;
      r_m_valid <= 1'b0;
      r_occ     <= OCC_EMPTY;
    end else begin
      r_state   <= w_state_nxt;
      r_s_ready <= (w_state_nxt != FULL);
      r_m_valid <= (w_state_nxt != EMPTY);
      r_occ     <= occ_of(w_state_nxt);
    end
  end

  assign o_s_ready = r_s_ready;
  assign o_m_valid = r_m_valid;
  assign o_occ     = r_occ;

endmodule

// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - elastic main+skid pipeline stage with stall counter (option: PIPE_SKID_FLUSH_EN)
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [1:0]       occ,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             w_flush;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_main_sel_skid;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [CNT_W-1:0] r_stall;

`ifdef PIPE_SKID_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  pipe_skid_ctrl u_ctrl (
    .clk             (clk),
    .reset           (reset),
    .i_s_valid       (s_valid),
    .i_m_ready       (m_ready),
    .i_flush         (w_flush),
    .o_s_ready       (s_ready),
    .o_m_valid       (m_valid),
    .o_occ           (occ),
    .o_load_main     (w_load_main),
    .o_load_skid     (w_load_skid),
    .o_main_sel_skid (w_main_sel_skid)
  );

  // Payload registers; contents are meaningless while not valid, so no reset
  always_ff @(posedge clk) begin
    if (w_load_main) r_main <= w_main_sel_skid ? r_skid : s_data;
    if (w_load_skid) r_skid <= s_data;
  end

  // Saturating count of cycles the consumer holds off a valid beat
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
    end else if (m_valid && !m_ready && (r_stall != {CNT_W{1'b1}})) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign m_data    = r_main;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_pipe_skid_buf.sv
// tb/tb_pipe_skid_buf.sv - self-checking bench for pipe_skid_buf with queue scoreboard
module tb_pipe_skid_buf;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic [1:0]       occ;
  logic [CNT_W-1:0] stall_cnt;

  pipe_skid_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef PIPE_SKID_FLUSH_EN
    .flush     (flush),
`endif
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .occ       (occ),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rst;
    logic             sv;
    logic [WIDTH-1:0] sd;
    logic             mr;
    logic [1:0]       exp_occ;
  } vec_t;

  vec_t             tbl[20];
  logic [WIDTH-1:0] q[$];
  int               m_stall;
  int               n_cmp;
  int               n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
    chk("s_ready", 32'(s_ready), 32'(q.size() != 2));
    chk("occ", 32'(occ), q.size());
    chk("stall_cnt", 32'(stall_cnt), m_stall);
    if (q.size() != 0) chk("m_data", m_data, q[0]);
  endtask

  // One cycle: check at negedge, drive, clock, update the reference model
  task automatic step(input logic rst, input logic sv, input logic [WIDTH-1:0] sd,
                      input logic mr, input logic fl, input logic do_chk);
    logic acc;
    logic dep;
    if (do_chk) check_model();
    reset   = rst;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    acc = sv && (q.size() != 2);
    dep = (q.size() != 0) && mr;
    @(posedge clk);
    if ((q.size() != 0) && !mr && (m_stall != SAT)) m_stall++;
    if (dep) void'(q.pop_front());
    if (acc) q.push_back(sd);
`ifdef PIPE_SKID_FLUSH_EN
    if (fl) q.delete();
`endif
    if (rst) begin
      q.delete();
      m_stall = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    m_stall = 0;
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

    //           rst   sv    data    mr    occ-before
    tbl[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 2'd0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd0};
    tbl[2]  = '{1'b0, 1'b1, 32'h1,  1'b1, 2'd0};
    tbl[3]  = '{1'b0, 1'b1, 32'h2,  1'b1, 2'd1};
    tbl[4]  = '{1'b0, 1'b1, 32'h3,  1'b1, 2'd1};
    tbl[5]  = '{1'b0, 1'b1, 32'h4,  1'b1, 2'd1};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd1};
    tbl[7]  = '{1'b0, 1'b1, 32'hA,  1'b0, 2'd0};
    tbl[8]  = '{1'b0, 1'b1, 32'hB,  1'b0, 2'd1};
    tbl[9]  = '{1'b0, 1'b1, 32'hC,  1'b0, 2'd2};
    tbl[10] = '{1'b0, 1'b1, 32'hC,  1'b0, 2'd2};
    tbl[11] = '{1'b0, 1'b1, 32'hC,  1'b1, 2'd2};
    tbl[12] = '{1'b0, 1'b1, 32'hC,  1'b1, 2'd1};
    tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd1};
    tbl[14] = '{1'b0, 1'b1, 32'h11, 1'b0, 2'd0};
    tbl[15] = '{1'b0, 1'b1, 32'h12, 1'b0, 2'd1};
    tbl[16] = '{1'b1, 1'b0, 32'h0,  1'b0, 2'd2};
    tbl[17] = '{1'b0, 1'b1, 32'h5,  1'b0, 2'd0};
    tbl[18] = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd1};
    tbl[19] = '{1'b0, 1'b0, 32'h0,  1'b1, 2'd0};

    @(negedge clk);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Idle, streaming, back-pressure
    for (int i = 0; i < 14; i++) begin
      chk("tbl_occ", 32'(occ), 32'(tbl[i].exp_occ));
      step(tbl[i].rst, tbl[i].sv, tbl[i].sd, tbl[i].mr, 1'b0, 1'b1);
    end
    chk("bp_stall_cycles", 32'(stall_cnt), 32'd3);

    // Reset while full, then a lone beat
    for (int i = 14; i < 20; i++) begin
      chk("tbl_occ", 32'(occ), 32'(tbl[i].exp_occ));
      step(tbl[i].rst, tbl[i].sv, tbl[i].sd, tbl[i].mr, 1'b0, 1'b1);
    end

`ifdef PIPE_SKID_FLUSH_EN
    // Flush while full with a same-cycle offer of 0x7
    step(1'b0, 1'b1, 32'h21, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h22, 1'b0, 1'b0, 1'b1);
    chk("pre_flush_occ", 32'(occ), 32'd2);
    step(1'b0, 1'b1, 32'h7, 1'b0, 1'b1, 1'b1);
    chk("flush_occ", 32'(occ), 32'd0);
    chk("flush_m_valid", 32'(m_valid), 32'd0);
    chk("flush_keeps_stall", 32'(stall_cnt), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
      chk("no_0x7_out", 32'(m_valid), 32'd0);
    end
`endif

    // Stall counter saturation
    step(1'b0, 1'b1, 32'h99, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("sat_stall", 32'(stall_cnt), 32'(SAT));
    step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("sat_stall_held", 32'(stall_cnt), 32'(SAT));
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    check_model();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_buf.md
Name: pipe_skid_buf

Overview:
- Elastic valid/ready pipeline stage: a registered main slot plus one skid slot.
- Sits between a producer and a consumer to break the combinational ready path. All outputs, including s_ready, are registered.
- Full throughput: 1 beat/cycle sustained; 1-cycle forward latency.
- Consumer-facing counterpart to plain enable-less flops: gives back-pressure-aware storage for datapath pipelines.

Parameters:
- WIDTH, 32, payload width in bits.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  producer beat valid.
- s_ready  out  1  buffer can accept a beat.
- s_data  in  WIDTH  producer payload.
- m_valid  out  1  consumer beat valid.
- m_ready  in  1  consumer accepts.
- m_data  out  WIDTH  consumer payload.
- occ  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  cycles with m_valid=1 and m_ready=0; saturates at all-ones.
- flush  in  1  present only with PIPE_SKID_FLUSH_EN.

Behaviour:
- One clock domain. Reset is synchronous and active-high, sampled on posedge clk.
- Reset values: state=EMPTY, m_valid=0, s_ready=1, occ=0, stall_cnt=0. m_data and skid data are not reset (don't-care while invalid).
- Transfers: an in-transfer occurs when s_valid&s_ready; an out-transfer occurs when m_valid&m_ready.
- s_valid with s_ready=0 is ignored. The producer must hold s_data stable until accepted.
- FSM states: EMPTY (occ=0), BUSY (occ=1, main valid), FULL (occ=2, main+skid valid).
- Outputs per state: m_valid = (state!=EMPTY); s_ready = (state!=FULL); m_data = main register.
- EMPTY:
  - in-transfer -> BUSY, main<=s_data.
  - otherwise stay.
- BUSY:
  - in & out -> BUSY, main<=s_data.
  - in & !out -> FULL, skid<=s_data.
  - !in & out -> EMPTY.
  - neither -> stay.
- FULL (no in-transfer possible):
  - out -> BUSY, main<=skid.
  - otherwise stay, data held.
- Ordering: beats leave strictly in arrival order; no beat is dropped or duplicated.
- Latency: a beat accepted in cycle N appears on m_data in cycle N+1 at the earliest.
- stall_cnt: increments by 1 each cycle with m_valid&!m_ready. It holds at 2^CNT_W-1 (no wrap) and only reset clears it.
- Reset mid-operation: all buffered beats are discarded; outputs return to their reset values the next cycle.
- m_ready toggling while m_valid=0 has no effect.

Optional Feature:
- Macro PIPE_SKID_FLUSH_EN.
- Defined:
  - Adds the flush input.
  - flush=1 at a clock edge -> state=EMPTY and occ=0 next cycle, discarding the main beat, the skid beat and any same-cycle in-transfer.
  - An out-transfer in the flush cycle still counts as completed by the consumer.
  - stall_cnt is not cleared by flush.
  - reset has priority over flush.
- Undefined:
  - No flush port.
  - Logic is identical to the flush-tied-low case.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] skid_state_t {EMPTY, BUSY, FULL}.
  - Occupancy constants OCC_EMPTY/OCC_ONE/OCC_FULL.
- Sub-module pipe_skid_ctrl: FSM plus s_ready/m_valid/occ generation and the main/skid load enables.
- The top level holds the data registers and the stall counter.

Test Plan:
- Reset, then idle -> s_ready=1, m_valid=0, occ=0, stall_cnt=0.
- Streaming: s_valid=1 with s_data=1,2,3,4 on consecutive cycles, m_ready=1 -> m_data=1,2,3,4 one cycle later; occ stays 1; s_ready never drops.
- Back-pressure: send 0xA then 0xB with m_ready=0 -> occ=2, s_ready=0; 0xC is held off. Then m_ready=1 -> out 0xA, 0xB, 0xC in order; stall_cnt equals the stalled cycles.
- Saturation: CNT_W=4, m_valid=1 and m_ready=0 for 20 cycles -> stall_cnt=15 and held.
- Reset with occ=2 -> next cycle m_valid=0, s_ready=1, occ=0. A subsequent beat 0x5 emerges alone.
- With PIPE_SKID_FLUSH_EN: occ=2, flush=1 and s_valid=1 (data 0x7) in the same cycle -> next cycle occ=0, m_valid=0; 0x7 never appears on m_data.
